aes_decrypt_iterative: RTL
==========================

# aes_decrypt_iterative

Iterative AES-128 inverse-cipher core. It recovers one 128-bit plaintext block from a ciphertext block, computing one round per clock. It consumes the 11 round keys produced by the existing `key_expansion` block and is the decrypt-side counterpart to the encrypt datapath. Input and output use valid/ready handshakes so it can sit between stream buffers or the host interface.

## Interface
- NUM_ROUNDS, 10: AES-128 round count; fixed, not meant to be overridden.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  ciphertext present on data_in
- in_ready  out  1  core can accept a block; equals (fsm == IDLE)
- data_in  in  128  ciphertext; byte 0 = bits [127:120], FIPS-197 column-major
- round_keys_flat  in  1408  rk[i] = bits [128*i+127 : 128*i], i = 0..10, from key_expansion
- out_valid  out  1  plaintext present on data_out
- out_ready  in  1  consumer accepts data_out
- data_out  out  128  plaintext, same byte order as data_in

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: state <= data_in ^ rk[10]; rnd <= 9; go to ROUND.
- ROUND (rnd 9..1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]); rnd <= rnd - 1.
- ROUND (rnd == 0):
  - data_out <= InvSubBytes(InvShiftRows(state)) ^ rk[0]; out_valid <= 1; go to DONE.
  - Do not apply InvMixColumns in this final round.
- DONE:
  - Hold data_out and out_valid = 1 stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0; go to IDLE.
- rnd is a 4-bit down-counter. It never wraps, because ROUND exits at rnd == 0.
- All GF(2^8) arithmetic uses polynomial 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.
- round_keys_flat must be stable from the accepting edge through the edge that sets out_valid. The core does not latch the keys; key changes in that window produce undefined plaintext and are not a verification target.
- in_valid while not in IDLE is ignored. The upstream side holds the block under standard valid/ready rules.
- The core takes no decrypt/mode pin: it always decrypts.

## Timing
- Reset (asynchronous) values:
  - fsm = IDLE, rnd = 0, state = 0.
  - data_out = 0, out_valid = 0.
  - in_ready = 1 once rst is deasserted.
- Latency: the accepting edge is E0. Edges E1..E10 perform rnd 9..0. out_valid rises right after E10, i.e. 10 edges after acceptance.
- Throughput with out_ready tied high:
  - Output handshake at E11, IDLE at E11, next accept at E12.
  - Result: one block per 12 cycles.
- Back-pressure: if out_ready is low, DONE persists indefinitely with data_out unchanged. in_ready stays 0.
- Reset mid-operation (ROUND or DONE):
  - Block is abandoned; no out_valid is produced.
  - Outputs return to reset values immediately, asynchronously.
- in_valid & in_ready at the same edge that out_valid & out_ready completes cannot occur, because in_ready = 0 in DONE.

## Structure
- Shared package `aes_pkg`:
  - NUM_ROUNDS and BLOCK_W = 128.
  - Inverse S-box function.
  - xtime and gf_mul helpers.
  - inv_shift_rows and inv_mix_columns functions.
- Sub-module `aes_inv_round`:
  - Purely combinational.
  - Inputs: state, round_key, is_final.
  - Output: next state.
  - Contains 16 inverse S-boxes.
  - Instantiated once; the top owns FSM, counter, state register and handshake.

## Test plan
- Reset, then FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (keys via key_expansion), ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: data_out = 00112233445566778899aabbccddeeff; out_valid exactly 10 edges after accept.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32.
  - Required: pt 3243f6a8885a308d313198a2e0370734.
- All-zero key, ct 66e94bd4ef8a2c3b884cfa59ca342b2e:
  - Required: pt all zeros.
  - Also check in_ready = 0 for all cycles from accept until the output handshake.
- Back-pressure: hold out_ready = 0 for 20 cycles after out_valid.
  - Required: data_out stable, in_ready = 0, and an in_valid pulse is not accepted.
  - Then out_ready = 1: single handshake, return to IDLE.
- Assert rst during rnd = 5 of a block.
  - Required: out_valid and data_out go to 0 asynchronously.
  - After release: in_ready = 1, and the next block (C.1 vector) decrypts correctly.
- Stream of 8 random blocks, encrypted by the existing encrypt core, with out_ready held high.
  - Required: round-trip plaintext matches the originals, and each block takes 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants and GF(2^8) / inverse-cipher helper functions for the
// AES-128 decrypt datapath.
//   NUM_ROUNDS : AES-128 round count (10)
//   BLOCK_W    : block width in bits (128)
//   S_*        : FSM state encodings for the iterative core
// Byte i of a block is bits [127-8*i -: 8]. The state is column-major:
// byte i sits at row i%4, column i/4.
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int BLOCK_W    = 128;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Inverse S-box. Entry 0x00 is in the most significant byte.
    localparam logic [2047:0] INV_SBOX_FLAT = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_FLAT[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse-cipher round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when
//   i_is_final is set).
// Ports:
//   i_state      : current 128-bit state
//   i_round_key  : round key for this round
//   i_is_final   : 1 for the last round (no InvMixColumns)
//   o_next_state : resulting state
// -----------------------------------------------------------------------------
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_round_key,
    input  logic               i_is_final,
    output logic [BLOCK_W-1:0] o_next_state
);

    logic [BLOCK_W-1:0] w_shifted;
    logic [BLOCK_W-1:0] w_subbed;
    logic [BLOCK_W-1:0] w_keyed;

    assign w_shifted = inv_shift_rows(i_state);

    // Byte-wise substitution is position independent, so the slice order
    // does not matter here.
    for (genvar g = 0; g < 16; g++) begin : g_sbox
        assign w_subbed[8*g +: 8] = inv_sbox(w_shifted[8*g +: 8]);
    end

    assign w_keyed      = w_subbed ^ i_round_key;
    assign o_next_state = i_is_final ? w_keyed : inv_mix_columns(w_keyed);

endmodule

// File: rtl/aes_decrypt_iterative.sv
// -----------------------------------------------------------------------------
// aes_decrypt_iterative
// Iterative AES-128 inverse cipher, one round per clock. Latency from the
// accepting edge to out_valid is 10 edges; with out_ready high a new block is
// accepted every 12 cycles.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : ciphertext handshake (in_ready high only in IDLE)
//   data_in         : ciphertext block
//   round_keys_flat : rk[i] = bits [128*i+127 : 128*i], i = 0..10; must stay
//                     stable while a block is in flight (not latched here)
//   out_valid/ready : plaintext handshake
//   data_out        : plaintext block, held until the output handshake
// -----------------------------------------------------------------------------
module aes_decrypt_iterative
    import aes_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [BLOCK_W-1:0]                  data_in,
    input  logic [(NUM_ROUNDS+1)*BLOCK_W-1:0]   round_keys_flat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BLOCK_W-1:0]                  data_out
);

    logic [1:0]         r_fsm;
    logic [3:0]         r_rnd;
    logic [BLOCK_W-1:0] r_state;
    logic [BLOCK_W-1:0] r_data_out;
    logic               r_out_valid;

    logic [BLOCK_W-1:0] w_rk_sel;
    logic [BLOCK_W-1:0] w_rk_last;
    logic               w_is_final;
    logic [BLOCK_W-1:0] w_next_state;

    // rnd * 128 as a shift; 11 bits covers the whole 1408-bit key bus.
    assign w_rk_sel   = round_keys_flat[{r_rnd, 7'd0} +: BLOCK_W];
    assign w_rk_last  = round_keys_flat[NUM_ROUNDS*BLOCK_W +: BLOCK_W];
    assign w_is_final = (r_rnd == 4'd0);

    aes_inv_round u_round (
        .i_state      (r_state),
        .i_round_key  (w_rk_sel),
        .i_is_final   (w_is_final),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_rnd       <= 4'd0;
            r_state     <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= data_in ^ w_rk_last;
                        r_rnd   <= 4'(NUM_ROUNDS - 1);
                        r_fsm   <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    // The last round writes straight to the output register.
                    if (w_is_final) begin
                        r_data_out  <= w_next_state;
                        r_out_valid <= 1'b1;
                        r_fsm       <= S_DONE;
                    end else begin
                        r_state <= w_next_state;
                        r_rnd   <= r_rnd - 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

endmodule
